// File: rtl/ula_contention.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ula_contention                                             |
// | Desc    : Z80 clock/T-state generator on the ULA clock with video    |
// |           RAM / ULA port contention, frame counters and interrupt.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ula_contention #(
    parameter int DIV         = 4,
    parameter int LINE_T      = 224,
    parameter int FRAME_LINES = 312,
    parameter int CONT_LINE0  = 64,
    parameter int CONT_LINES  = 192,
    parameter int CONT_T      = 128,
    parameter int INT_T       = 32
) (
    input  logic        clk_ula,
    input  logic        nreset,
    input  logic        cpu_turbo,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic [15:0] addr,
    output logic        clk_cpu,
    output logic        cpu_ce,
    output logic        stall,
    output logic        int_n,
    output logic [7:0]  hcount,
    output logic [8:0]  vcount
);
    // DIV is assumed to be a power of two, at least 4
    localparam int                   c_PHASE_W    = $clog2(DIV);
    localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(DIV - 1);
    localparam logic [c_PHASE_W-1:0] c_PHASE_HALF = c_PHASE_W'(DIV / 2);
    localparam logic [c_PHASE_W-1:0] c_PHASE_ONE  = c_PHASE_W'(1);
    localparam logic [7:0]           c_H_LAST     = 8'(LINE_T - 1);
    localparam logic [8:0]           c_V_LAST     = 9'(FRAME_LINES - 1);
    localparam logic [8:0]           c_CONT_V0    = 9'(CONT_LINE0);
    localparam logic [8:0]           c_CONT_V1    = 9'(CONT_LINE0 + CONT_LINES);
    localparam logic [7:0]           c_CONT_H     = 8'(CONT_T);
    localparam logic [7:0]           c_INT_H      = 8'(INT_T);

    logic [c_PHASE_W-1:0] r_phase;
    logic [7:0]           r_hcount;
    logic [8:0]           r_vcount;
    logic [2:0]           r_delay;
    logic                 r_armed;
    logic                 r_turbo;
    logic                 r_clk_cpu;
    logic                 r_cpu_ce;
    logic                 r_int_n;

    logic                 w_boundary;
    logic [c_PHASE_W-1:0] w_phase_next;
    logic [7:0]           w_hnext;
    logic [8:0]           w_vnext;
    logic                 w_contended_req;
    logic                 w_window;
    logic [2:0]           w_table;
    logic                 w_stall_start;
    logic [2:0]           w_delay_next;
    logic                 w_turbo_next;
    logic                 w_unused;

    assign w_unused = ^addr[13:1];

    always_comb begin
        w_boundary   = (r_phase == c_PHASE_LAST);
        w_phase_next = w_boundary ? '0 : r_phase + c_PHASE_ONE;

        w_hnext = r_hcount;
        w_vnext = r_vcount;
        if (w_boundary) begin
            if (r_hcount == c_H_LAST) begin
                w_hnext = '0;
                w_vnext = (r_vcount == c_V_LAST) ? '0 : r_vcount + 9'd1;
            end else begin
                w_hnext = r_hcount + 8'd1;
            end
        end

        w_contended_req = (!mreq_n && (addr[15:14] == 2'b01)) || (!iorq_n && !addr[0]);
        w_window        = (w_vnext >= c_CONT_V0) && (w_vnext < c_CONT_V1) && (w_hnext < c_CONT_H);
        w_table         = (w_hnext[2:0] >= 3'd6) ? 3'd0 : 3'd6 - w_hnext[2:0];
        w_stall_start   = w_boundary && w_contended_req && w_window && !r_armed
                          && (r_delay == 3'd0) && !cpu_turbo;

        w_delay_next = r_delay;
        if (w_boundary) begin
            if (r_delay != 3'd0) begin
                w_delay_next = r_delay - 3'd1;
            end else if (w_stall_start) begin
                w_delay_next = w_table;
            end
        end

        w_turbo_next = w_boundary ? cpu_turbo : r_turbo;
    end

    // Outputs are registered from next-state values so they line up with the counters
    always_ff @(posedge clk_ula) begin
        if (!nreset) begin
            r_phase   <= '0;
            r_hcount  <= '0;
            r_vcount  <= '0;
            r_delay   <= '0;
            r_armed   <= 1'b0;
            r_turbo   <= 1'b0;
            r_clk_cpu <= 1'b0;
            r_cpu_ce  <= 1'b0;
            r_int_n   <= 1'b1;
        end else begin
            r_phase  <= w_phase_next;
            r_hcount <= w_hnext;
            r_vcount <= w_vnext;
            r_delay  <= w_delay_next;
            r_turbo  <= w_turbo_next;

            if (w_stall_start) begin
                r_armed <= 1'b1;
            end else if (mreq_n && iorq_n) begin
                r_armed <= 1'b0;
            end

            r_int_n <= !((w_vnext == '0) && (w_hnext < c_INT_H));

            if (w_delay_next != 3'd0) begin
                r_clk_cpu <= 1'b1;
                r_cpu_ce  <= 1'b0;
            end else if (w_turbo_next) begin
                r_clk_cpu <= !w_phase_next[c_PHASE_W-2];
                r_cpu_ce  <= &w_phase_next[c_PHASE_W-2:0];
            end else begin
                r_clk_cpu <= (w_phase_next < c_PHASE_HALF);
                r_cpu_ce  <= (w_phase_next == c_PHASE_LAST);
            end
        end
    end

    assign clk_cpu = r_clk_cpu;
    assign cpu_ce  = r_cpu_ce;
    assign stall   = (r_delay != 3'd0);
    assign int_n   = r_int_n;
    assign hcount  = r_hcount;
    assign vcount  = r_vcount;

endmodule
`default_nettype wire

// File: doc/ula_contention.md
Name: ula_contention

Overview:
- Consumer side of the ULA CPU clock: runs on the ULA clock, derives the Z80 clock and T-state timing, and stretches the CPU clock for contended accesses to video RAM (0x4000-0x7FFF) and ULA I/O ports (even addresses).
- Also tracks frame position: T-state within line and line within frame.
- Generates the 50 Hz maskable interrupt.
- Sits between the clock generator output (clk_ula) and the Z80 core.

Parameters:
- DIV, 4, clk_ula cycles per normal T-state (14 MHz / 4 = 3.5 MHz).
- LINE_T, 224, T-states per scan line.
- FRAME_LINES, 312, lines per frame.
- CONT_LINE0, 64, first line of the contended window.
- CONT_LINES, 192, number of contended lines.
- CONT_T, 128, contended T-states at the start of each line.
- INT_T, 32, interrupt pulse length in T-states.

Ports:
- clk_ula  input  1  ULA clock (14 MHz); the only clock.
- nreset  input  1  synchronous, active-low reset.
- cpu_turbo  input  1  1 = CPU at 2x (DIV/2 per T-state), contention disabled.
- mreq_n  input  1  Z80 MREQ, active low.
- iorq_n  input  1  Z80 IORQ, active low.
- addr  input  16  Z80 address bus.
- clk_cpu  output  1  CPU clock level.
- cpu_ce  output  1  one clk_ula cycle pulse per CPU T-state advanced.
- stall  output  1  high while a contention delay is being inserted.
- int_n  output  1  frame interrupt, active low.
- hcount  output  8  T-state within line, 0..LINE_T-1.
- vcount  output  9  line within frame, 0..FRAME_LINES-1.

Behaviour:
- Reset (nreset=0 at a clk_ula edge): phase=0, hcount=0, vcount=0, clk_cpu=0, cpu_ce=0, stall=0, int_n=1, delay counter=0, armed flag=0.
- Video phase counter counts 0..DIV-1 continuously. Wrap from DIV-1 marks a video T-state boundary.
- At each video boundary:
  - hcount increments; at LINE_T-1 it wraps to 0 and vcount increments.
  - vcount wraps from FRAME_LINES-1 to 0.
  - Frame timing never stalls and is unaffected by cpu_turbo.
- int_n=0 while vcount==0 and hcount<INT_T, else 1.
  - The pulse is exactly INT_T*DIV clk_ula cycles, registered.
- Normal mode (cpu_turbo=0):
  - clk_cpu=1 for phases 0..DIV/2-1, 0 for the rest, registered.
  - cpu_ce pulses in the cycle where phase==DIV-1, unless stalled.
- Contended request: (mreq_n==0 and addr[15:14]==2'b01) or (iorq_n==0 and addr[0]==0).
- Contention window: vcount in [CONT_LINE0, CONT_LINE0+CONT_LINES) and hcount<CONT_T.
- Delay table, indexed by hcount[2:0]: 0→6, 1→5, 2→4, 3→3, 4→2, 5→1, 6→0, 7→0.
- Stall start: evaluated at a video boundary. Required conditions:
  - contended request is true;
  - window is true, taking the post-increment hcount/vcount;
  - armed==0;
  - delay counter==0;
  - cpu_turbo==0.
  When all hold:
  - load the delay counter from the table, using the post-increment hcount;
  - set armed=1.
  A table value of 0 sets armed but inserts no stall.
- While the delay counter is nonzero:
  - stall=1;
  - clk_cpu is held 1;
  - cpu_ce=0;
  - the counter decrements at each video boundary.
  - When it reaches 0, normal clocking resumes at phase 0 of the next T-state.
- armed clears when mreq_n and iorq_n are both 1. This gives one contention per access.
- Turbo (cpu_turbo=1):
  - clk_cpu toggles every DIV/4 cycles, so the CPU period is DIV/2;
  - cpu_ce pulses once per CPU period;
  - no new stalls start.
  - A stall already in progress completes.
  - A change of cpu_turbo takes effect at the next video boundary.
- Simultaneous stall end and new contended request: a new stall starts only after armed clears, so back-to-back accesses each see their own table delay.
- Reset mid-stall: stall, delay counter and armed clear on the same edge; no residual stretch.

Test Plan:
- Reset then free-run 69888*4 cycles:
  - hcount/vcount wrap at 223/311;
  - int_n low for exactly 128 cycles starting at vcount=0, hcount=0;
  - 69888 cpu_ce pulses seen.
- mreq_n=0, addr=0x4000, issued so that the boundary lands on vcount=64, hcount=0:
  - stall=1 for 24 cycles, clk_cpu held 1, 0 cpu_ce pulses in that span.
- Same access landing at hcount=6 → no stall. Landing at hcount=13 (index 5) → stall for 4 cycles.
- Uncontended cases → no stall, cpu_ce every 4 cycles:
  - addr=0x8000 at vcount=100, hcount=0;
  - addr=0x4000 at vcount=10;
  - iorq_n=0 with addr=0x00FF (port odd? no: 0xFF is odd).
  - Then iorq_n=0 with addr=0x00FE in the window → stall per table.
- cpu_turbo=1 with a contended access in the window:
  - no stall;
  - cpu_ce every 2 cycles;
  - vcount/hcount rates unchanged.
- nreset=0 during the third cycle of a 6-T-state stall:
  - all outputs at reset values next edge;
  - after release, the first cpu_ce occurs 4 cycles later.
